apb_sram_arbiter: RTL and testbench
===================================

Name: apb_sram_arbiter

Overview:
Two-requester arbiter and APB sequencer in front of the single-ported `sram` slave. It lets the instruction-fetch requester (m0) and the load/store requester (m1) share one memory. The block accepts simple request/ack transactions and converts each into an APB SETUP/ACCESS sequence. Arbitration is round-robin, and an ACCESS-phase timeout turns a hung slave into an error response.

Parameters:
ADDR_WIDTH, 32, byte address width on master and slave sides
DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 = 4 bits
TIMEOUT, 255, max ACCESS cycles with s_pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  synchronous active-low reset
m0_req  in  1  m0 request; held high and stable until m0_ack
m0_we  in  1  m0 write enable
m0_addr  in  ADDR_WIDTH  m0 byte address; unaligned addresses allowed, passed through unchanged
m0_wdata  in  DATA_WIDTH  m0 write data
m0_strb  in  4  m0 byte strobes
m0_ack  out  1  one-cycle completion pulse to m0
m0_err  out  1  error qualifier, valid only with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_strb, m1_ack, m1_err  as m0, for requester m1 (one port per name)
m_rdata  out  DATA_WIDTH  shared read data, valid with either ack, held until the next ack
s_psel  out  1  APB select to slave
s_penable  out  1  APB enable to slave
s_pwrite  out  1  APB write
s_paddr  out  ADDR_WIDTH  APB address
s_pdata  out  DATA_WIDTH  APB write data
s_pstb  out  4  APB byte strobes
s_prdata  in  DATA_WIDTH  slave read data
s_pready  in  1  slave ready
s_perr  in  1  slave error

Behaviour:
- Reset (presetn=0 at an edge):
  - State goes to IDLE; last_grant=1, so m0 wins the first tie.
  - All outputs 0: acks, errs, m_rdata and every s_* signal. Timeout counter cleared.
- Reset mid-transaction: same as above. The slave sees s_psel drop on the next cycle and no ack is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from registered state only; there is no req-to-slave combinational path.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester not equal to last_grant.
  - On grant: latch the winner's we/addr/wdata/strb into the s_* registers, set last_grant=winner, go to SETUP.
- SETUP: s_psel=1, s_penable=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - Drive s_psel=1, s_penable=1 and increment the wait counter each cycle.
  - s_pready=1 sampled: capture s_prdata into m_rdata and s_perr into err, go to DONE.
  - TIMEOUT!=0, counter reaches TIMEOUT and s_pready still 0: abort. Capture m_rdata=0, err=1, go to DONE.
- DONE:
  - s_psel=s_penable=0. Granted requester's ack=1 and err=captured value for this one cycle; the other requester's ack stays 0.
  - All req inputs are ignored in DONE. Next state IDLE.
- Latency, no slave wait states: req seen in IDLE at cycle N, SETUP at N+1, ACCESS at N+2, ack at N+3. Each slave wait state adds one cycle.
- Requester contract: req dropped on the cycle after ack unless a new transaction is wanted. Back-to-back requests from one requester re-arbitrate in IDLE.
- Fairness: the losing requester is granted next, before a second grant to the winner. Worst-case wait is one transaction.
- Write and read data are passed through unmodified; address alignment is handled by the slave.
- Counter width is $clog2(TIMEOUT+1); it clears on entry to SETUP.

Test Plan:
- m0 read only, addr=0x10, slave pready on first ACCESS cycle, s_prdata=0xDEADBEEF -> s_psel rises at N+1, s_penable at N+2; m0_ack=1, m_rdata=0xDEADBEEF, m0_err=0 at N+3; m1_ack=0 throughout.
- m1 write, addr=0x21, wdata=0x11223344, strb=4'b0011 -> slave sees s_pwrite=1, s_paddr=0x21, s_pdata=0x11223344, s_pstb=4'b0011 in SETUP and ACCESS; single m1_ack pulse.
- m0 and m1 both requesting continuously from reset -> grants alternate m0,m1,m0,m1 over 4 transactions; each ack is 4 cycles after the previous one.
- Slave holds pready low for 3 ACCESS cycles, then s_pready=1, s_perr=1 -> ack 3 cycles later than baseline with err=1.
- TIMEOUT=4, slave never asserts pready -> after 4 ACCESS cycles s_psel drops, requester gets ack=1, err=1, m_rdata=0; FSM returns to IDLE.
- presetn pulled low during ACCESS -> next cycle all s_* and acks are 0 and state is IDLE; after release, a held m1_req is granted (last_grant=1 restored, m0 idle).

Source files
------------

// File: rtl/apb_sram_arbiter.sv
// apb_sram_arbiter
// Shares the single-ported sram APB slave between two requesters:
// m0 (instruction fetch) and m1 (load/store). Each requester issues a
// request/ack transaction. The winner's command is registered and played
// out to the slave as an APB SETUP/ACCESS pair. Arbitration is round-robin.
// An ACCESS phase that the slave never completes is aborted after TIMEOUT
// cycles and returned to the requester as an error.
//
// Ports
//   pclk, presetn            clock; synchronous active-low reset
//   m0_req/we/addr/wdata/strb  requester 0 command (req held until ack)
//   m0_ack, m0_err           one-cycle completion pulse and error flag
//   m1_*                     same set of signals for requester 1
//   m_rdata                  shared read data, held until the next ack
//   s_psel/penable/pwrite    APB control to the slave
//   s_paddr/pdata/pstb       APB address, write data and byte strobes
//   s_prdata/pready/perr     APB response from the slave
module apb_sram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_strb,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_strb,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    s_psel,
  output logic                    s_penable,
  output logic                    s_pwrite,
  output logic [ADDR_WIDTH-1:0]   s_paddr,
  output logic [DATA_WIDTH-1:0]   s_pdata,
  output logic [DATA_WIDTH/8-1:0] s_pstb,
  input  logic [DATA_WIDTH-1:0]   s_prdata,
  input  logic                    s_pready,
  input  logic                    s_perr
);

  // A zero TIMEOUT still needs a legal one-bit counter; its value is unused then.
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic                 grant;
  logic                 last_grant;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 start;
  logic                 win;
  logic                 timeout_hit;

  // cnt holds the number of ACCESS cycles already completed. The current
  // cycle is therefore the TIMEOUT-th one when cnt equals TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // State register. The rest of the datapath lives in its own block below.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and arbitration decode. When both requesters ask, the grant
  // goes to the one that was not served last. This gives strict alternation
  // under contention.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    win        = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          start = 1'b1;
          win   = ~last_grant;
        end else if (m0_req || m1_req) begin
          start = 1'b1;
          win   = m1_req;
        end
        if (start) begin
          state_next = SETUP;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (s_pready || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command capture, wait counter and response capture. The slave-side
  // command comes only from these registers, so a requester's inputs never
  // reach the slave combinationally. A slave response takes priority over
  // an abort that lands on the same cycle.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      cnt        <= '0;
      m_rdata    <= '0;
      s_pwrite   <= 1'b0;
      s_paddr    <= '0;
      s_pdata    <= '0;
      s_pstb     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant      <= win;
            last_grant <= win;
            cnt        <= '0;
            s_pwrite   <= win ? m1_we    : m0_we;
            s_paddr    <= win ? m1_addr  : m0_addr;
            s_pdata    <= win ? m1_wdata : m0_wdata;
            s_pstb     <= win ? m1_strb  : m0_strb;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (s_pready) begin
            m_rdata <= s_prdata;
            err_q   <= s_perr;
          end else if (timeout_hit) begin
            m_rdata <= '0;
            err_q   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // APB strobes and requester acks are decoded from the registered state only.
  always_comb begin
    s_psel    = (state == SETUP) || (state == ACCESS);
    s_penable = (state == ACCESS);
    m0_ack    = (state == DONE) && !grant;
    m1_ack    = (state == DONE) && grant;
    m0_err    = (state == DONE) && !grant && err_q;
    m1_err    = (state == DONE) && grant && err_q;
  end

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Testbench for apb_sram_arbiter.
// It runs directed single-requester vectors from a table and hand-written
// contention and reset sequences. It then runs randomized traffic that is
// checked against a transaction-level model of arbitration and timing.
module tb_apb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk     = 1'b0;
  logic          presetn  = 1'b0;
  logic          m0_req   = 1'b0;
  logic          m0_we    = 1'b0;
  logic [AW-1:0] m0_addr  = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [3:0]    m0_strb  = '0;
  logic          m0_ack;
  logic          m0_err;
  logic          m1_req   = 1'b0;
  logic          m1_we    = 1'b0;
  logic [AW-1:0] m1_addr  = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [3:0]    m1_strb  = '0;
  logic          m1_ack;
  logic          m1_err;
  logic [DW-1:0] m_rdata;
  logic          s_psel;
  logic          s_penable;
  logic          s_pwrite;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pdata;
  logic [3:0]    s_pstb;
  logic [DW-1:0] s_prdata = '0;
  logic          s_pready = 1'b0;
  logic          s_perr   = 1'b0;

  int checks = 0;
  int fails  = 0;

  apb_sram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_rdata(m_rdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pdata(s_pdata), .s_pstb(s_pstb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_perr(s_perr)
  );

  always #5 pclk = ~pclk;

  // Directed single-requester transaction with its expected response.
  // A waits value of TO or more means the slave never answers.
  typedef struct {
    int          master;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        perr;
    int          expAck;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Move to 1 time unit after the next rising edge. Outputs are sampled
  // there and the next inputs are driven there.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
    end
  endtask

  task automatic driveSlave(input logic rdy, input logic [31:0] rd, input logic er);
    s_pready = rdy;
    s_prdata = rd;
    s_perr   = er;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_psel"},    s_psel,    0);
    checkOutput({tag, "_penable"}, s_penable, 0);
    checkOutput({tag, "_pwrite"},  s_pwrite,  0);
    checkOutput({tag, "_paddr"},   s_paddr,   0);
    checkOutput({tag, "_pdata"},   s_pdata,   0);
    checkOutput({tag, "_pstb"},    s_pstb,    0);
    checkOutput({tag, "_m0_ack"},  m0_ack,    0);
    checkOutput({tag, "_m1_ack"},  m1_ack,    0);
    checkOutput({tag, "_m0_err"},  m0_err,    0);
    checkOutput({tag, "_m1_err"},  m1_err,    0);
    checkOutput({tag, "_m_rdata"}, m_rdata,   0);
  endtask

  // Run one vector from IDLE. The task plays both requester and slave and
  // records when each event happens relative to the cycle the request is raised.
  task automatic runVector(input vec_t v, input int idx);
    int          k, ackTick, ackCount, otherAcks, pselTick, penTick;
    logic        ownAck, ownErr, otherAck, errAtAck, pselAtAck;
    logic [31:0] rdAtAck;
    string       p;
    p = $sformatf("v%0d", idx);
    k = 0; ackTick = -1; ackCount = 0; otherAcks = 0; pselTick = -1; penTick = -1;
    errAtAck = 1'b0; pselAtAck = 1'b1; rdAtAck = '0;
    applyStimulus(v.master, 1'b1, v.we, v.addr, v.wdata, v.strb);
    driveSlave(1'b0, '0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      tick();
      ownAck   = (v.master == 0) ? m0_ack : m1_ack;
      ownErr   = (v.master == 0) ? m0_err : m1_err;
      otherAck = (v.master == 0) ? m1_ack : m0_ack;
      if (s_psel && pselTick < 0) pselTick = t;
      if (s_penable && penTick < 0) penTick = t;
      if (t == 1 || t == 2) begin
        checkOutput($sformatf("%s_pwrite_t%0d", p, t), s_pwrite, v.we);
        checkOutput($sformatf("%s_paddr_t%0d", p, t),  s_paddr,  v.addr);
        checkOutput($sformatf("%s_pdata_t%0d", p, t),  s_pdata,  v.wdata);
        checkOutput($sformatf("%s_pstb_t%0d", p, t),   s_pstb,   v.strb);
      end
      if (ownAck) begin
        ackCount++;
        if (ackTick < 0) begin
          ackTick   = t;
          rdAtAck   = m_rdata;
          errAtAck  = ownErr;
          pselAtAck = s_psel;
        end
        applyStimulus(v.master, 1'b0, 1'b0, '0, '0, '0);
      end
      if (otherAck) otherAcks++;
      if (s_psel && s_penable) begin
        if (k >= v.waits) driveSlave(1'b1, v.prdata, v.perr);
        else driveSlave(1'b0, $urandom, 1'($urandom_range(0, 1)));
        k++;
      end else begin
        driveSlave(1'b0, '0, 1'b0);
      end
    end
    checkOutput({p, "_pselTick"},  pselTick,  1);
    checkOutput({p, "_penTick"},   penTick,   2);
    checkOutput({p, "_ackTick"},   ackTick,   v.expAck);
    checkOutput({p, "_ackCount"},  ackCount,  1);
    checkOutput({p, "_otherAck"},  otherAcks, 0);
    checkOutput({p, "_err"},       errAtAck,  v.expErr);
    checkOutput({p, "_rdata"},     rdAtAck,   v.expRdata);
    checkOutput({p, "_pselAtAck"}, pselAtAck, 0);
    checkOutput({p, "_rdataHeld"}, m_rdata,   v.expRdata);
  endtask

  // Randomized traffic against a transaction-level model. The model tracks
  // the edge where the arbiter next samples requests, the round-robin owner,
  // and the phase window of the current transaction, derived from the
  // slave's wait count.
  task automatic runRandom(input int cycles);
    logic        rq[2];
    logic        rwe[2];
    logic [31:0] raddr[2];
    logic [31:0] rwdata[2];
    logic [3:0]  rstrb[2];
    int          lastG, freeEdge, gEdge, accLen, winner, waits, kAcc;
    bit          active, setup, access, done;
    logic [31:0] held, slaveRd, expRd, taddr, twdata;
    logic        slaveErr, expErr, twe;
    logic [3:0]  tstrb;
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; rwe[m] = 1'b0; raddr[m] = '0; rwdata[m] = '0; rstrb[m] = '0;
    end
    lastG = 1; freeEdge = 1; gEdge = 0; accLen = 0; winner = 0; waits = 0; kAcc = 0;
    active = 1'b0; held = '0; slaveRd = '0; expRd = '0; slaveErr = 1'b0; expErr = 1'b0;
    twe = 1'b0; taddr = '0; twdata = '0; tstrb = '0;
    for (int x = 0; x < cycles; x++) begin
      if (x > 0) tick();
      setup  = active && (x == gEdge);
      access = active && (x > gEdge) && (x <= gEdge + accLen);
      done   = active && (x == gEdge + accLen + 1);
      if (done) held = expRd;
      checkOutput("rnd_psel",    s_psel,    setup || access);
      checkOutput("rnd_penable", s_penable, access);
      checkOutput("rnd_m0_ack",  m0_ack,    done && winner == 0);
      checkOutput("rnd_m1_ack",  m1_ack,    done && winner == 1);
      checkOutput("rnd_m0_err",  m0_err,    done && winner == 0 && expErr);
      checkOutput("rnd_m1_err",  m1_err,    done && winner == 1 && expErr);
      checkOutput("rnd_m_rdata", m_rdata,   held);
      if (setup || access) begin
        checkOutput("rnd_pwrite", s_pwrite, twe);
        checkOutput("rnd_paddr",  s_paddr,  taddr);
        checkOutput("rnd_pdata",  s_pdata,  twdata);
        checkOutput("rnd_pstb",   s_pstb,   tstrb);
      end
      // Slave: answers on the planned ACCESS cycle and drives noise elsewhere.
      if (access) begin
        if (kAcc >= waits) driveSlave(1'b1, slaveRd, slaveErr);
        else driveSlave(1'b0, $urandom, 1'($urandom_range(0, 1)));
        kAcc++;
      end else begin
        driveSlave(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
      // Requesters: the served one either drops or issues a fresh request.
      // Idle ones start new requests at random and hold them until served.
      if (done) begin
        active = 1'b0;
        rq[winner] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!rq[m] && $urandom_range(0, 2) == 0) begin
          rq[m] = 1'b1; rwe[m] = 1'($urandom_range(0, 1)); raddr[m] = $urandom;
          rwdata[m] = $urandom; rstrb[m] = 4'($urandom_range(0, 15));
        end
        applyStimulus(m, rq[m], rwe[m], raddr[m], rwdata[m], rstrb[m]);
      end
      // Arbitration happens at the edge closing this cycle when the arbiter is free.
      if (!active && (x + 1) == freeEdge) begin
        if (rq[0] || rq[1]) begin
          winner   = (rq[0] && rq[1]) ? 1 - lastG : (rq[1] ? 1 : 0);
          lastG    = winner;
          gEdge    = x + 1;
          active   = 1'b1;
          kAcc     = 0;
          waits    = $urandom_range(0, 6);
          accLen   = (waits < TO) ? waits + 1 : TO;
          slaveRd  = $urandom;
          slaveErr = 1'($urandom_range(0, 1));
          expRd    = (waits < TO) ? slaveRd : 32'h0;
          expErr   = (waits < TO) ? slaveErr : 1'b1;
          twe = rwe[winner]; taddr = raddr[winner]; twdata = rwdata[winner]; tstrb = rstrb[winner];
          freeEdge = gEdge + accLen + 3;
        end else begin
          freeEdge = x + 2;
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   nAck;
    int   ackWho[4];
    int   ackAt[4];

    vecs[0] = '{master:0, we:1'b0, addr:32'h10, wdata:32'h0, strb:4'h0, waits:0,
                prdata:32'hDEADBEEF, perr:1'b0, expAck:3, expErr:1'b0, expRdata:32'hDEADBEEF};
    vecs[1] = '{master:1, we:1'b1, addr:32'h21, wdata:32'h11223344, strb:4'b0011, waits:0,
                prdata:32'hA5A5A5A5, perr:1'b0, expAck:3, expErr:1'b0, expRdata:32'hA5A5A5A5};
    vecs[2] = '{master:0, we:1'b0, addr:32'h40, wdata:32'h0, strb:4'hF, waits:3,
                prdata:32'hCAFEF00D, perr:1'b1, expAck:6, expErr:1'b1, expRdata:32'hCAFEF00D};
    vecs[3] = '{master:1, we:1'b0, addr:32'h80, wdata:32'h0, strb:4'hF, waits:99,
                prdata:32'h12121212, perr:1'b0, expAck:6, expErr:1'b1, expRdata:32'h0};
    vecs[4] = '{master:0, we:1'b1, addr:32'h7, wdata:32'h87654321, strb:4'b1000, waits:2,
                prdata:32'h12345678, perr:1'b0, expAck:5, expErr:1'b0, expRdata:32'h12345678};
    vecs[5] = '{master:1, we:1'b0, addr:32'hFFFFFFFF, wdata:32'h0, strb:4'h0, waits:1,
                prdata:32'h0BADC0DE, perr:1'b0, expAck:4, expErr:1'b0, expRdata:32'h0BADC0DE};

    tick();
    tick();
    checkIdleOutputs("reset");
    presetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], i);
    end

    // Both requesters hold requests from reset. Grants alternate starting
    // with m0, and acks arrive every 4 cycles.
    $display("[TB] contention sequence");
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b1, 32'h200, 32'h55, 4'h1);
    driveSlave(1'b1, 32'h600D0000, 1'b0);
    nAck = 0;
    for (int i = 0; i < 4; i++) begin
      ackWho[i] = -1;
      ackAt[i]  = -1;
    end
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (m0_ack || m1_ack) begin
        if (nAck < 4) begin
          ackWho[nAck] = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
          ackAt[nAck]  = t;
        end
        nAck++;
      end
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    driveSlave(1'b0, '0, 1'b0);
    checkOutput("rr_ackCount", nAck, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_who%0d", i), ackWho[i], i % 2);
      checkOutput($sformatf("rr_at%0d", i),  ackAt[i],  3 + 4 * i);
    end
    tick();

    // Reset during ACCESS of an m0 transfer. Outputs clear on the next cycle,
    // and the restored last_grant lets m0 win the first tie after release.
    $display("[TB] reset during ACCESS sequence");
    applyStimulus(0, 1'b1, 1'b1, 32'h44, 32'h99, 4'hF);
    driveSlave(1'b0, '0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid_inAccess", s_penable, 1);
    presetn = 1'b0;
    tick();
    checkIdleOutputs("midReset");
    presetn = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h88, 32'h0, 4'h3);
    driveSlave(1'b1, 32'h77, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) begin
        checkOutput("post_setup0_psel",  s_psel,  1);
        checkOutput("post_setup0_paddr", s_paddr, 32'h44);
      end
      if (t == 3) begin
        checkOutput("post_m0_ack", m0_ack, 1);
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (t == 5) begin
        checkOutput("post_setup1_psel",  s_psel,  1);
        checkOutput("post_setup1_paddr", s_paddr, 32'h88);
      end
      if (t == 7) begin
        checkOutput("post_m1_ack", m1_ack, 1);
        checkOutput("post_rdata",  m_rdata, 32'h77);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
      end
    end

    $display("[TB] randomized traffic");
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    runRandom(600);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
